jk_excite_seq: RTL and testbench
================================

# jk_excite_seq

Sequenced excitation driver and self-checker for the team's single-bit JK flip-flop (`jk_ff`). It is the inverse of the flip-flop: it takes a target state sequence, encodes each target into a J/K pair via the excitation table, and drives the FF one step per clock. It also reads back `q` and flags any step where the FF did not reach the target. It sits beside `jk_ff` in test harnesses and in small sequencer designs that build state from JK cells.

## Interface
- `LEN`, 8, number of steps in a pattern (≥1)
- `IW`, `$clog2(LEN)` (min 1), index width
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  pulse; latches `pattern` and begins a run (ignored unless IDLE)
- `pattern`  in  LEN  target states; bit 0 is step 0
- `q`  in  1  FF output read back
- `j`  out  1  registered J drive
- `k`  out  1  registered K drive
- `busy`  out  1  high in DRIVE and FLUSH
- `done`  out  1  one-cycle pulse at end of run
- `err`  out  1  sticky mismatch flag for current/last run
- `err_idx`  out  IW  index of first mismatching step
- `err_cnt`  out  IW+1  number of mismatching steps

## Operation
- States: IDLE → DRIVE → FLUSH → DONE → IDLE.
- IDLE: `j=k=0`. On `start`:
  - latch `pattern` into `pat`
  - `idx=0`, `exp_q=q`
  - present `enc(pat[0], exp_q)`
  - clear `err`, `err_idx`, `err_cnt`
  - go to DRIVE
- DRIVE, each edge:
  - If `idx≥1`, compare `q` with `pat[idx-1]`.
  - Set `exp_q=pat[idx]`.
  - If `idx<LEN-1`: `idx++`, present `enc(pat[idx+1], pat[idx])`.
  - Else: present `j=k=0` and go to FLUSH.
- FLUSH, one edge: compare `q` with `pat[LEN-1]`, go to DONE.
- DONE, one cycle: `done=1`, `j=k=0`, then IDLE. `err`, `err_idx`, `err_cnt` hold until the next `start` or `rst`.
- Compare on mismatch:
  - `err_cnt++`, saturating at LEN
  - if `err` was 0: `err=1`, `err_idx=` step index
- `start` during busy or DONE: ignored; `pattern` is not resampled.
- LEN=1: DRIVE lasts one edge and goes straight to FLUSH.
- `rst` asserted mid-run: the next edge forces IDLE. All outputs and counters return to reset values. The run is abandoned and no `done` is produced.

## Timing
- Reset values: `j=0`, `k=0`, `busy=0`, `done=0`, `err=0`, `err_idx=0`, `err_cnt=0`; state IDLE.
- The `start` edge is E0. Step i is presented on `j`/`k` from E_i to E_{i+1}, and the FF captures it at E_{i+1}.
- Step i is checked at E_{i+2}, one clock after capture.
- `busy` is high from after E0 through E_{LEN+1}.
- `done` is high for the cycle after E_{LEN+1}.
- Run length: LEN+2 cycles from `start` to `done`. The next `start` is accepted in the cycle after `done`.
- `err`/`err_idx` update on the edge of the failing compare.

## Configuration
- Macro `JK_TOGGLE_EN`.
- Undefined (set/reset encoding): `enc(t,·) = {J=t, K=~t}`. The encoding is independent of the current state.
- Defined (toggle encoding):
  - `enc(t,c) = {0,0}` when `t==c`
  - `enc(t,c) = {1,1}` when `t!=c`
  - For step 0, `c` is the `q` sampled at `start`.
- Check logic and timing are identical in both builds.

## Structure
- Package `jk_pkg`:
  - state enum `jk_seq_state_t` (IDLE, DRIVE, FLUSH, DONE)
  - J/K encoding constants: HOLD=2'b00, RESET=2'b01, SET=2'b10, TOGGLE=2'b11, packed as {J,K}
- Sub-module `jk_excite`: combinational `(t, c) → {j,k}` encoder. The `JK_TOGGLE_EN` selection lives only here.
- Top holds the FSM, `pat`/`idx`/`exp_q` registers, compare, and error bookkeeping.

## Test plan
- Default build, LEN=8, `jk_ff` attached, `pattern=8'b1011_0010`, pulse `start`:
  - `j`/`k` follow `{0,1},{1,0},{0,1},{0,1},{1,0},{1,0},{0,1},{1,0}` on E0..E7
  - `done` after E9
  - `err=0`, `err_cnt=0`
- `JK_TOGGLE_EN`, `q=0` at start, `pattern=8'b0000_0110`:
  - `{j,k}` = 00,11,00,11,00,00,00,00
  - no error
- Fault injection: tie `q` stuck at 0, `pattern=8'hFF` → `err=1`, `err_idx=0`, `err_cnt=8` at `done`.
- Pulse `start` at E3 of a run → ignored; the original pattern completes and `done` comes at E9.
- Assert `rst` at E4:
  - next edge shows all outputs at reset values
  - no `done`
  - a fresh `start` runs a full clean pass
- LEN=1, `pattern=1'b1` → `j=1,k=0` at E0, `j=k=0` at E1, compare at E2, `done` after E2.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared types for the JK excitation sequencer:
// FSM states and {J,K} drive codes.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    FLUSH,
    DONE
  } jk_seq_state_t;

  localparam logic [1:0] HOLD   = 2'b00;
  localparam logic [1:0] RESET  = 2'b01;
  localparam logic [1:0] SET    = 2'b10;
  localparam logic [1:0] TOGGLE = 2'b11;

endpackage

// File: rtl/jk_excite.sv
// Excitation encoder: target t, current c -> {J,K}.
// JK_TOGGLE_EN selects toggle/hold coding; otherwise set/reset.
import jk_pkg::*;

module jk_excite (
  input  logic       t,
  input  logic       c,
  output logic [1:0] jk
);

`ifdef JK_TOGGLE_EN
  always_comb begin
    jk = (t == c) ? HOLD : TOGGLE;
  end
`else
  logic unused_c;
  assign unused_c = c;

  always_comb begin
    jk = t ? SET : RESET;
  end
`endif

endmodule

// File: rtl/jk_excite_seq.sv
// Drives a JK flip-flop through a target pattern and checks q.
// Encoding chosen in jk_excite (JK_TOGGLE_EN).
import jk_pkg::*;

module jk_excite_seq #(
  parameter int LEN = 8,
  parameter int IW  = (LEN > 1) ? $clog2(LEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LEN-1:0] pattern,
  input  logic          q,
  output logic          j,
  output logic          k,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [IW-1:0] err_idx,
  output logic [IW:0]   err_cnt
);

  localparam logic [IW-1:0] LAST = IW'(LEN - 1);
  localparam logic [IW:0]   CMAX = (IW + 1)'(LEN);

  jk_seq_state_t state_q, state_d;
  logic [LEN:0]  pat_q, pat_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          expq_q, expq_d;
  logic [1:0]    jk_q, jk_d;
  logic          err_q, err_d;
  logic [IW-1:0] err_idx_q, err_idx_d;
  logic [IW:0]   err_cnt_q, err_cnt_d;

  logic          enc_t, enc_c;
  logic [1:0]    enc_jk;
  logic          chk;
  logic [IW-1:0] chk_idx;

  jk_excite u_enc (
    .t  (enc_t),
    .c  (enc_c),
    .jk (enc_jk)
  );

  // pat_q shifts so bit 0 is the current step and bit 1 the next
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    idx_d     = idx_q;
    expq_d    = expq_q;
    jk_d      = HOLD;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    err_cnt_d = err_cnt_q;
    enc_t     = pat_q[1];
    enc_c     = pat_q[0];
    chk       = 1'b0;
    chk_idx   = idx_q - IW'(1);
    unique case (state_q)
      IDLE: begin
        enc_t = pattern[0];
        enc_c = q;
        if (start) begin
          state_d   = DRIVE;
          pat_d     = {1'b0, pattern};
          idx_d     = '0;
          expq_d    = q;
          jk_d      = enc_jk;
          err_d     = 1'b0;
          err_idx_d = '0;
          err_cnt_d = '0;
        end
      end
      DRIVE: begin
        chk    = (idx_q != '0);
        expq_d = pat_q[0];
        if (idx_q != LAST) begin
          idx_d = idx_q + IW'(1);
          pat_d = pat_q >> 1;
          jk_d  = enc_jk;
        end else begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        chk     = 1'b1;
        chk_idx = LAST;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // expq_q holds the target of the step being checked
    if (chk && (q != expq_q)) begin
      if (err_cnt_q != CMAX) begin
        err_cnt_d = err_cnt_q + (IW + 1)'(1);
      end
      if (!err_q) begin
        err_d     = 1'b1;
        err_idx_d = chk_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      idx_q     <= '0;
      expq_q    <= 1'b0;
      jk_q      <= HOLD;
      err_q     <= 1'b0;
      err_idx_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      idx_q     <= idx_d;
      expq_q    <= expq_d;
      jk_q      <= jk_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign j       = jk_q[1];
  assign k       = jk_q[0];
  assign busy    = (state_q == DRIVE) || (state_q == FLUSH);
  assign done    = (state_q == DONE);
  assign err     = err_q;
  assign err_idx = err_idx_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_jk_excite_seq.sv
// Directed bench: LEN=8 and LEN=1 sequencers each driving a
// behavioural JK flip-flop, with a stuck-at-0 hook on q.
module tb_jk_excite_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start = 1'b0;
  logic [7:0] pattern = 8'h00;
  logic       q, j, k, busy, done, err;
  logic [2:0] err_idx;
  logic [3:0] err_cnt;
  logic       ff_q = 1'b0;
  logic       stuck = 1'b0;

  logic       start1 = 1'b0;
  logic [0:0] pattern1 = 1'b0;
  logic       q1, j1, k1, busy1, done1, err1;
  logic [0:0] err_idx1;
  logic [1:0] err_cnt1;
  logic       ff1_q = 1'b0;

  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  assign q  = stuck ? 1'b0 : ff_q;
  assign q1 = ff1_q;

  always @(posedge clk) begin
    if (rst) ff_q <= 1'b0;
    else case ({j, k})
      2'b01:   ff_q <= 1'b0;
      2'b10:   ff_q <= 1'b1;
      2'b11:   ff_q <= ~ff_q;
      default: ff_q <= ff_q;
    endcase
  end

  always @(posedge clk) begin
    if (rst) ff1_q <= 1'b0;
    else case ({j1, k1})
      2'b01:   ff1_q <= 1'b0;
      2'b10:   ff1_q <= 1'b1;
      2'b11:   ff1_q <= ~ff1_q;
      default: ff1_q <= ff1_q;
    endcase
  end

  always @(posedge clk) done_cnt <= done_cnt + (done ? 1 : 0);

  jk_excite_seq #(.LEN(8)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pattern (pattern),
    .q       (q),
    .j       (j),
    .k       (k),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .err_idx (err_idx),
    .err_cnt (err_cnt)
  );

  jk_excite_seq #(.LEN(1)) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .start   (start1),
    .pattern (pattern1),
    .q       (q1),
    .j       (j1),
    .k       (k1),
    .busy    (busy1),
    .done    (done1),
    .err     (err1),
    .err_idx (err_idx1),
    .err_cnt (err_cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0h exp %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full LEN=8 run: j/k per step, flush, then done/err at E9
  task automatic run8(input string tag, input logic [7:0] p,
                      input logic [15:0] exp_jk, input logic exp_err,
                      input logic [2:0] exp_idx, input logic [3:0] exp_cnt);
    @(negedge clk);
    pattern = p;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_jk%0d", tag, i), 32'({j, k}),
          32'(exp_jk[2*i +: 2]));
      if (i == 0) chk({tag, "_busy0"}, 32'(busy), 32'd1);
      step();
    end
    chk({tag, "_jk_flush"}, 32'({j, k}), 32'd0);
    chk({tag, "_done_e8"}, 32'(done), 32'd0);
    step();
    chk({tag, "_done_e9"}, 32'(done), 32'd1);
    chk({tag, "_busy_e9"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_err_idx"}, 32'(err_idx), 32'(exp_idx));
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_cnt));
    step();
    chk({tag, "_done_gone"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [15:0] t06, tb2, tff;
    logic [1:0]  t1;
    int dc;
`ifdef JK_TOGGLE_EN
    t06 = 16'h00CC;
    tb2 = 16'hF33C;
    tff = 16'h0003;
    t1  = 2'b11;
`else
    t06 = 16'h5569;
    tb2 = 16'h9A59;
    tff = 16'hAAAA;
    t1  = 2'b10;
`endif
    repeat (3) step();
    chk("rst_jk", 32'({j, k}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'({err, err_idx, err_cnt}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run8("p06", 8'h06, t06, 1'b0, 3'd0, 4'd0);
    run8("pb2", 8'hB2, tb2, 1'b0, 3'd0, 4'd0);

    stuck = 1'b1;
    run8("stuck", 8'hFF, tff, 1'b1, 3'd0, 4'd8);
    @(negedge clk);
    stuck = 1'b0;

    // start mid-run must be ignored
    @(negedge clk);
    pattern = 8'hB2;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    @(negedge clk);
    pattern = 8'h00;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ign_busy_e3", 32'(busy), 32'd1);
    repeat (5) step();
    chk("ign_done_e8", 32'(done), 32'd0);
    step();
    chk("ign_done_e9", 32'(done), 32'd1);
    chk("ign_err", 32'(err), 32'd0);
    step();

    // reset mid-run with an error already recorded
    stuck = 1'b1;
    @(negedge clk);
    pattern = 8'hFF;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    chk("mid_err_set", 32'(err), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("mr_jk", 32'({j, k}), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_err", 32'({err, err_idx, err_cnt}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    stuck = 1'b0;
    dc = done_cnt;
    repeat (12) step();
    chk("mr_no_done", 32'(done_cnt), 32'(dc));
    run8("post_rst", 8'h06, t06, 1'b0, 3'd0, 4'd0);

    // LEN=1 instance
    @(negedge clk);
    pattern1 = 1'b1;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("l1_jk_e0", 32'({j1, k1}), 32'(t1));
    step();
    chk("l1_jk_e1", 32'({j1, k1}), 32'd0);
    chk("l1_busy_e1", 32'(busy1), 32'd1);
    chk("l1_done_e1", 32'(done1), 32'd0);
    step();
    chk("l1_done_e2", 32'(done1), 32'd1);
    chk("l1_err", 32'({err1, err_cnt1}), 32'd0);
    step();
    chk("l1_idle", 32'({busy1, done1}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
